uart_half_duplex_port: RTL and testbench

//  Parametrised half-duplex UART port: one shared serial line, one FSM owning TX and RX
//  in turn. Successor to the fixed 8N1 separate RX/TX pair. Adds configurable data

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_half_duplex_port_if.sv | 34 +++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_half_duplex_port.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_half_duplex_port.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the half-duplex UART port.
//  state_t      : FSM state encoding (one FSM owns both TX and RX on the shared line)
//  PARITY_*     : parity mode constants for PARITY_MODE
//  parity_bit() : parity bit for a (pre-masked) data word under a given mode
package uart_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    TURNAROUND
  } state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Odd: data ones plus parity bit is odd. Even: that total is even.
  // Unused data bits must already be zero.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_half_duplex_port_if.sv
// Bus-side and pad-side signals of the half-duplex UART port.
//  master : the byte-interface user / pad model (drives TX request and line input)
//  slave  : the UART port itself
//  i_Tx_DV, i_Tx_Byte        : TX request strobe and data
//  o_Tx_Ready, o_Tx_Done     : TX accept window and end-of-frame pulse
//  o_Line_Out, o_Line_OE     : tristate pad drive value and enable
//  i_Line_In                 : asynchronous line value from the pad
//  o_Rx_DV, o_Rx_Byte        : received frame pulse and data
//  o_Rx_Parity_Err/Frame_Err : error flags, valid with o_Rx_DV
interface uart_half_duplex_port_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;
  logic       o_Tx_Done;
  logic       o_Line_Out;
  logic       o_Line_OE;
  logic       i_Line_In;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Parity_Err;
  logic       o_Rx_Frame_Err;

  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Line_In,
    input  o_Tx_Ready, o_Tx_Done, o_Line_Out, o_Line_OE,
           o_Rx_DV, o_Rx_Byte, o_Rx_Parity_Err, o_Rx_Frame_Err
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Line_In,
    output o_Tx_Ready, o_Tx_Done, o_Line_Out, o_Line_OE,
           o_Rx_DV, o_Rx_Byte, o_Rx_Parity_Err, o_Rx_Frame_Err
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer shared by TX bits, RX sampling and line turnaround.
//  clk, rst   : clock, asynchronous active-high reset
//  load       : reload counter with load_value (takes priority)
//  load_value : number of enabled cycles until o_Expire
//  enable     : count while high; o_Expire is gated by it
//  o_Expire   : high during the last cycle of the loaded period
// The counter stops at zero and only restarts through an explicit load.
module uart_bit_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             o_Expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign o_Expire = enable && (count == WIDTH'(1));

endmodule

// File: rtl/uart_half_duplex_port.sv
// Parametrised half-duplex UART port on a single shared serial line.
//  i_Clock : system clock
//  i_Reset : asynchronous active-high reset
//  bus     : uart_half_duplex_port_if.slave (TX request/ready/done, pad drive and
//            enable, line input, RX data/valid/error flags)
// One FSM owns the line: TX frames are start, DATA_BITS LSB first, optional parity,
// STOP_BITS ones; RX samples each bit at its centre. Every frame is followed by a
// turnaround guard during which no TX is accepted but a new start edge restarts RX.
module uart_half_duplex_port
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = 87,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned PARITY_MODE     = 0,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned TURNAROUND_BITS = 2
) (
  input logic i_Clock,
  input logic i_Reset,
  uart_half_duplex_port_if.slave bus
);

  localparam int unsigned TA_CYCLES = CLKS_PER_BIT * TURNAROUND_BITS;
  localparam int unsigned TMAX      = (TA_CYCLES > CLKS_PER_BIT) ? TA_CYCLES : CLKS_PER_BIT;
  localparam int unsigned TW        = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_BIT  = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_TA   = TW'(TA_CYCLES);

  localparam logic [2:0] LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK  = 8'((1 << DATA_BITS) - 1);
  localparam logic [1:0] PMODE      = 2'(PARITY_MODE);
  localparam logic       HAS_PARITY = (PARITY_MODE != 0);
  localparam logic       HAS_TA     = (TA_CYCLES != 0);

  state_t     state_q, state_n;
  logic [2:0] bit_idx_q, bit_idx_n;
  logic [7:0] tx_data_q, tx_data_n;
  logic [7:0] rx_shift_q, rx_shift_n;
  logic       rx_par_q, rx_par_n;
  logic       rx_ferr_q, rx_ferr_n;
  logic       rx_from_ta_q, rx_from_ta_n;
  logic [7:0] rx_byte_q, rx_byte_n;
  logic       rx_perr_out_q, rx_perr_out_n;
  logic       rx_ferr_out_q, rx_ferr_out_n;
  logic       rx_dv_q, rx_dv_n;

  logic sync1_q, sync2_q, line_d_q, armed_q;

  logic          tx_ready, accept, start_edge, stop_ferr;
  logic          line_out, line_oe, tx_done;
  logic          t_load, t_expire;
  logic [TW-1:0] t_val;

  // Line synchroniser and edge history idle high; armed_q delays Ready by one edge
  // after reset release.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      line_d_q <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= bus.i_Line_In;
      sync2_q  <= sync1_q;
      line_d_q <= sync2_q;
      armed_q  <= 1'b1;
    end
  end

  assign tx_ready   = armed_q && (state_q == IDLE);
  assign accept     = bus.i_Tx_DV && tx_ready;
  assign start_edge = line_d_q && !sync2_q;
  assign stop_ferr  = rx_ferr_q || !sync2_q;

  uart_bit_timer #(.WIDTH(TW)) u_timer (
    .clk        (i_Clock),
    .rst        (i_Reset),
    .load       (t_load),
    .load_value (t_val),
    .enable     (state_q != IDLE),
    .o_Expire   (t_expire)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= IDLE;
      bit_idx_q     <= '0;
      tx_data_q     <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_from_ta_q  <= 1'b0;
      rx_byte_q     <= '0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_out_q <= 1'b0;
      rx_dv_q       <= 1'b0;
    end else begin
      state_q       <= state_n;
      bit_idx_q     <= bit_idx_n;
      tx_data_q     <= tx_data_n;
      rx_shift_q    <= rx_shift_n;
      rx_par_q      <= rx_par_n;
      rx_ferr_q     <= rx_ferr_n;
      rx_from_ta_q  <= rx_from_ta_n;
      rx_byte_q     <= rx_byte_n;
      rx_perr_out_q <= rx_perr_out_n;
      rx_ferr_out_q <= rx_ferr_out_n;
      rx_dv_q       <= rx_dv_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    bit_idx_n     = bit_idx_q;
    tx_data_n     = tx_data_q;
    rx_shift_n    = rx_shift_q;
    rx_par_n      = rx_par_q;
    rx_ferr_n     = rx_ferr_q;
    rx_from_ta_n  = rx_from_ta_q;
    rx_byte_n     = rx_byte_q;
    rx_perr_out_n = rx_perr_out_q;
    rx_ferr_out_n = rx_ferr_out_q;
    rx_dv_n       = 1'b0;
    line_out      = 1'b1;
    line_oe       = 1'b0;
    tx_done       = 1'b0;
    t_load        = 1'b0;
    t_val         = T_BIT;

    case (state_q)
      IDLE: begin
        // TX has priority over a coincident start edge.
        if (accept) begin
          tx_data_n = bus.i_Tx_Byte & DATA_MASK;
          state_n   = TX_START;
          t_load    = 1'b1;
        end else if (start_edge) begin
          state_n      = RX_START;
          rx_from_ta_n = 1'b0;
          rx_shift_n   = '0;
          rx_par_n     = 1'b0;
          rx_ferr_n    = 1'b0;
          t_load       = 1'b1;
          t_val        = T_HALF;
        end
      end

      TX_START: begin
        line_out = 1'b0;
        line_oe  = 1'b1;
        if (t_expire) begin
          state_n   = TX_DATA;
          bit_idx_n = '0;
          t_load    = 1'b1;
        end
      end

      TX_DATA: begin
        line_out = tx_data_q[bit_idx_q];
        line_oe  = 1'b1;
        if (t_expire) begin
          t_load = 1'b1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_n = '0;
            state_n   = HAS_PARITY ? TX_PARITY : TX_STOP;
          end else begin
            bit_idx_n = bit_idx_q + 3'd1;
          end
        end
      end

      TX_PARITY: begin
        line_out = parity_bit(tx_data_q, PMODE);
        line_oe  = 1'b1;
        if (t_expire) begin
          state_n   = TX_STOP;
          bit_idx_n = '0;
          t_load    = 1'b1;
        end
      end

      TX_STOP: begin
        line_oe = 1'b1;
        if (t_expire) begin
          if (bit_idx_q == LAST_STOP) begin
            tx_done = 1'b1;
            state_n = HAS_TA ? TURNAROUND : IDLE;
            t_load  = HAS_TA;
            t_val   = T_TA;
          end else begin
            bit_idx_n = bit_idx_q + 3'd1;
            t_load    = 1'b1;
          end
        end
      end

      RX_START: begin
        if (t_expire) begin
          if (!sync2_q) begin
            state_n   = RX_DATA;
            bit_idx_n = '0;
            t_load    = 1'b1;
          end else begin
            // False start: resume whatever was interrupted; a turnaround restarts its guard.
            state_n = rx_from_ta_q ? TURNAROUND : IDLE;
            t_load  = rx_from_ta_q;
            t_val   = T_TA;
          end
        end
      end

      RX_DATA: begin
        if (t_expire) begin
          rx_shift_n[bit_idx_q] = sync2_q;
          t_load = 1'b1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_n = '0;
            state_n   = HAS_PARITY ? RX_PARITY : RX_STOP;
          end else begin
            bit_idx_n = bit_idx_q + 3'd1;
          end
        end
      end

      RX_PARITY: begin
        if (t_expire) begin
          rx_par_n  = sync2_q;
          state_n   = RX_STOP;
          bit_idx_n = '0;
          t_load    = 1'b1;
        end
      end

      RX_STOP: begin
        if (t_expire) begin
          if (bit_idx_q == LAST_STOP) begin
            rx_byte_n     = rx_shift_q;
            rx_perr_out_n = HAS_PARITY && (rx_par_q != parity_bit(rx_shift_q, PMODE));
            rx_ferr_out_n = stop_ferr;
            rx_dv_n       = 1'b1;
            state_n       = HAS_TA ? TURNAROUND : IDLE;
            t_load        = HAS_TA;
            t_val         = T_TA;
          end else begin
            rx_ferr_n = stop_ferr;
            bit_idx_n = bit_idx_q + 3'd1;
            t_load    = 1'b1;
          end
        end
      end

      TURNAROUND: begin
        if (start_edge) begin
          state_n      = RX_START;
          rx_from_ta_n = 1'b1;
          rx_shift_n   = '0;
          rx_par_n     = 1'b0;
          rx_ferr_n    = 1'b0;
          t_load       = 1'b1;
          t_val        = T_HALF;
        end else if (t_expire) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.o_Tx_Ready      = tx_ready;
  assign bus.o_Tx_Done       = tx_done;
  assign bus.o_Line_Out      = line_out;
  assign bus.o_Line_OE       = line_oe;
  assign bus.o_Rx_DV         = rx_dv_q;
  assign bus.o_Rx_Byte       = rx_byte_q;
  assign bus.o_Rx_Parity_Err = rx_perr_out_q;
  assign bus.o_Rx_Frame_Err  = rx_ferr_out_q;

endmodule

// File: tb/tb_uart_half_duplex_port.sv
// Bench for uart_half_duplex_port: three configurations (8N1, 7E2, 8O1) at 16 clocks/bit.
module tb_uart_half_duplex_port;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       fe;
  } rx_exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  uart_half_duplex_port_if if_a ();
  uart_half_duplex_port_if if_b ();
  uart_half_duplex_port_if if_c ();

  uart_half_duplex_port #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                          .STOP_BITS(1), .TURNAROUND_BITS(2)) dut_a (
    .i_Clock (clk), .i_Reset (rst), .bus (if_a));
  uart_half_duplex_port #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2),
                          .STOP_BITS(2), .TURNAROUND_BITS(2)) dut_b (
    .i_Clock (clk), .i_Reset (rst), .bus (if_b));
  uart_half_duplex_port #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1),
                          .STOP_BITS(1), .TURNAROUND_BITS(2)) dut_c (
    .i_Clock (clk), .i_Reset (rst), .bus (if_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame builder: start, data LSB first, parity, stops.
  function automatic void build_frame(input logic [7:0] b, input int nb, input int pm,
                                      input int ns, input bit flip_par, input bit zero_stop,
                                      output logic [15:0] bits, output int len);
    int   ones;
    logic par;
    bits = '1;
    len  = 0;
    ones = 0;
    bits[len] = 1'b0;
    len++;
    for (int i = 0; i < nb; i++) begin
      bits[len] = b[i];
      if (b[i]) ones++;
      len++;
    end
    if (pm != 0) begin
      par = (pm == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      bits[len] = par ^ flip_par;
      len++;
    end
    for (int i = 0; i < ns; i++) begin
      bits[len] = ~zero_stop;
      len++;
    end
  endfunction

  // ---------------- scoreboards ----------------
  logic    tx_bit_q[$];
  int      tx_len_q[$];
  rx_exp_t rxq_a[$];
  rx_exp_t rxq_b[$];
  rx_exp_t rxq_c[$];

  bit mon_tx_en = 1'b1;
  int oe_cnt = 0;
  int done_at = 0;
  int done_cnt_a = 0;
  int dv_cnt_a = 0, dv_cnt_b = 0, dv_cnt_c = 0;
  int dv_cyc_a = 0;

  always @(negedge clk) begin
    logic eb;
    int   el;
    if (if_a.o_Tx_Done) done_cnt_a++;
    if (mon_tx_en) begin
      if (if_a.o_Line_OE) begin
        oe_cnt++;
        if (if_a.o_Tx_Done) done_at = oe_cnt;
        if ((oe_cnt % CPB) == CPB / 2) begin
          if (tx_bit_q.size() == 0) check("tx_bit_expected", 32'(tx_bit_q.size()), 32'd1);
          else begin
            eb = tx_bit_q.pop_front();
            check("tx_line_bit", 32'(if_a.o_Line_Out), 32'(eb));
          end
        end
      end else if (oe_cnt != 0) begin
        if (tx_len_q.size() == 0) check("tx_frame_expected", 32'(tx_len_q.size()), 32'd1);
        else begin
          el = tx_len_q.pop_front();
          check("tx_oe_cycles", 32'(oe_cnt), 32'(el));
          check("tx_done_cycle", 32'(done_at), 32'(el));
        end
        oe_cnt  = 0;
        done_at = 0;
      end
    end
  end

  always @(negedge clk) begin
    rx_exp_t e;
    if (if_a.o_Rx_DV) begin
      dv_cnt_a++;
      dv_cyc_a = cyc;
      if (rxq_a.size() == 0) check("rx_a_expected", 32'(rxq_a.size()), 32'd1);
      else begin
        e = rxq_a.pop_front();
        check("rx_a_byte", 32'(if_a.o_Rx_Byte), 32'(e.b));
        check("rx_a_perr", 32'(if_a.o_Rx_Parity_Err), 32'(e.pe));
        check("rx_a_ferr", 32'(if_a.o_Rx_Frame_Err), 32'(e.fe));
      end
    end
  end

  always @(negedge clk) begin
    rx_exp_t e;
    if (if_b.o_Rx_DV) begin
      dv_cnt_b++;
      if (rxq_b.size() == 0) check("rx_b_expected", 32'(rxq_b.size()), 32'd1);
      else begin
        e = rxq_b.pop_front();
        check("rx_b_byte", 32'(if_b.o_Rx_Byte), 32'(e.b));
        check("rx_b_perr", 32'(if_b.o_Rx_Parity_Err), 32'(e.pe));
        check("rx_b_ferr", 32'(if_b.o_Rx_Frame_Err), 32'(e.fe));
      end
    end
  end

  always @(negedge clk) begin
    rx_exp_t e;
    if (if_c.o_Rx_DV) begin
      dv_cnt_c++;
      if (rxq_c.size() == 0) check("rx_c_expected", 32'(rxq_c.size()), 32'd1);
      else begin
        e = rxq_c.pop_front();
        check("rx_c_byte", 32'(if_c.o_Rx_Byte), 32'(e.b));
        check("rx_c_perr", 32'(if_c.o_Rx_Parity_Err), 32'(e.pe));
        check("rx_c_ferr", 32'(if_c.o_Rx_Frame_Err), 32'(e.fe));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       if_a.i_Line_In = v;
      1:       if_b.i_Line_In = v;
      default: if_c.i_Line_In = v;
    endcase
  endtask

  // poke: frame bit index at which a one-cycle TX request is raised on port A (-1: none)
  task automatic send_frame(input int sel, input logic [15:0] bits, input int len, input int poke);
    for (int i = 0; i < len; i++) begin
      set_line(sel, bits[i]);
      if (i == poke) begin
        if_a.i_Tx_DV = 1'b1;
        tick(1);
        if_a.i_Tx_DV = 1'b0;
        tick(CPB - 1);
      end else begin
        tick(CPB);
      end
    end
    set_line(sel, 1'b1);
  endtask

  task automatic push_tx(input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) tx_bit_q.push_back(bits[i]);
    tx_len_q.push_back(len * CPB);
  endtask

  task automatic wait_ready_a(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (if_a.o_Tx_Ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_empty(input int sel, input int max, output bit ok);
    int n;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      n = (sel == 0) ? rxq_a.size() : (sel == 1) ? rxq_b.size() : rxq_c.size();
      if (n == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] bits;
    int          len;
    bit          ok;
    rx_exp_t     e;
    int          done_snap;

    if_a.i_Tx_DV = 1'b0; if_a.i_Tx_Byte = '0; if_a.i_Line_In = 1'b1;
    if_b.i_Tx_DV = 1'b0; if_b.i_Tx_Byte = '0; if_b.i_Line_In = 1'b1;
    if_c.i_Tx_DV = 1'b0; if_c.i_Tx_Byte = '0; if_c.i_Line_In = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line_out", 32'(if_a.o_Line_Out), 32'd1);
    check("rst_line_oe", 32'(if_a.o_Line_OE), 32'd0);
    check("rst_tx_ready", 32'(if_a.o_Tx_Ready), 32'd0);
    check("rst_tx_done", 32'(if_a.o_Tx_Done), 32'd0);
    check("rst_rx_dv", 32'(if_a.o_Rx_DV), 32'd0);
    check("rst_rx_byte", 32'(if_a.o_Rx_Byte), 32'd0);
    check("rst_perr", 32'(if_a.o_Rx_Parity_Err), 32'd0);
    check("rst_ferr", 32'(if_a.o_Rx_Frame_Err), 32'd0);
    check("rst_b_line_out", 32'(if_b.o_Line_Out), 32'd1);
    check("rst_c_ready", 32'(if_c.o_Tx_Ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_edge", 32'(if_a.o_Tx_Ready), 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", 32'(if_a.o_Tx_Ready), 32'd1);

    // 8N1 transmit of 0xA5
    tick(1);
    build_frame(8'hA5, 8, 0, 1, 1'b0, 1'b0, bits, len);
    push_tx(bits, len);
    if_a.i_Tx_Byte = 8'hA5;
    if_a.i_Tx_DV   = 1'b1;
    tick(1);
    if_a.i_Tx_DV = 1'b0;
    check("tx_ready_falls", 32'(if_a.o_Tx_Ready), 32'd0);
    check("tx_oe_rises", 32'(if_a.o_Line_OE), 32'd1);
    check("tx_start_bit", 32'(if_a.o_Line_Out), 32'd0);
    wait_ready_a(400, ok);
    check("tx_a5_ready_return", 32'(ok), 32'd1);
    check("tx_a5_done_count", 32'(done_cnt_a), 32'd1);

    // 7E2 receive of 0x35, correct parity
    tick(1);
    e = '{b: 8'h35, pe: 1'b0, fe: 1'b0};
    rxq_b.push_back(e);
    build_frame(8'h35, 7, 2, 2, 1'b0, 1'b0, bits, len);
    send_frame(1, bits, len, -1);
    wait_empty(1, 100, ok);
    check("rx_b_delivered", 32'(ok), 32'd1);
    check("rx_b_dv_count", 32'(dv_cnt_b), 32'd1);

    // 8O1 receive of 0x0F with wrong parity and a zero stop bit
    tick(1);
    e = '{b: 8'h0F, pe: 1'b1, fe: 1'b1};
    rxq_c.push_back(e);
    build_frame(8'h0F, 8, 1, 1, 1'b1, 1'b1, bits, len);
    send_frame(2, bits, len, -1);
    wait_empty(2, 100, ok);
    check("rx_c_delivered", 32'(ok), 32'd1);
    check("rx_c_dv_count", 32'(dv_cnt_c), 32'd1);

    // False start on port A: line low for 5 cycles only
    tick(1);
    check("fs_ready_before", 32'(if_a.o_Tx_Ready), 32'd1);
    if_a.i_Line_In = 1'b0;
    tick(5);
    if_a.i_Line_In = 1'b1;
    check("fs_ready_low_in_rx_start", 32'(if_a.o_Tx_Ready), 32'd0);
    wait_ready_a(40, ok);
    check("fs_ready_return", 32'(ok), 32'd1);
    check("fs_no_dv", 32'(dv_cnt_a), 32'd0);

    // 8N1 receive of 0x3C on port A with TX requests during RX and turnaround
    tick(1);
    e = '{b: 8'h3C, pe: 1'b0, fe: 1'b0};
    rxq_a.push_back(e);
    build_frame(8'h3C, 8, 0, 1, 1'b0, 1'b0, bits, len);
    if_a.i_Tx_Byte = 8'hFF;
    send_frame(0, bits, len, 4);
    check("rx_a_dv_before_ta_poke", 32'(dv_cnt_a), 32'd1);
    check("ta_ready_low", 32'(if_a.o_Tx_Ready), 32'd0);
    if_a.i_Tx_DV = 1'b1;
    tick(1);
    if_a.i_Tx_DV = 1'b0;
    wait_ready_a(100, ok);
    check("ta_ready_return", 32'(ok), 32'd1);
    check("ta_ready_delay", 32'(cyc - dv_cyc_a), 32'd32);
    tick(3);
    check("ta_no_queued_tx", 32'(if_a.o_Line_OE), 32'd0);

    // TX request in the same cycle as a detected start edge: TX wins
    build_frame(8'h5A, 8, 0, 1, 1'b0, 1'b0, bits, len);
    push_tx(bits, len);
    if_a.i_Tx_Byte = 8'h5A;
    if_a.i_Line_In = 1'b0;
    tick(2);
    if_a.i_Tx_DV = 1'b1;
    tick(1);
    if_a.i_Tx_DV = 1'b0;
    check("sim_tx_won", 32'(if_a.o_Line_OE), 32'd1);
    tick(20);
    if_a.i_Line_In = 1'b1;
    wait_ready_a(400, ok);
    check("sim_ready_return", 32'(ok), 32'd1);
    check("sim_no_dv", 32'(dv_cnt_a), 32'd1);
    check("sim_done_count", 32'(done_cnt_a), 32'd2);

    // Reset in the middle of TX data bit 4 (0xA5 bit 4 is 0)
    tick(1);
    mon_tx_en = 1'b0;
    done_snap = done_cnt_a;
    if_a.i_Tx_Byte = 8'hA5;
    if_a.i_Tx_DV   = 1'b1;
    tick(1);
    if_a.i_Tx_DV = 1'b0;
    tick(5 * CPB + CPB / 2);
    check("rst_tx_bit4_low", 32'(if_a.o_Line_Out), 32'd0);
    check("rst_tx_oe_before", 32'(if_a.o_Line_OE), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_line_out", 32'(if_a.o_Line_Out), 32'd1);
    check("rst_mid_oe", 32'(if_a.o_Line_OE), 32'd0);
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_before_edge", 32'(if_a.o_Tx_Ready), 32'd0);
    @(negedge clk);
    check("rst_mid_ready_after_edge", 32'(if_a.o_Tx_Ready), 32'd1);
    check("rst_mid_no_done", 32'(done_cnt_a), 32'(done_snap));
    check("rst_mid_no_dv", 32'(dv_cnt_a), 32'd1);

    // Every scoreboard entry consumed
    check("end_tx_bits_left", 32'(tx_bit_q.size()), 32'd0);
    check("end_tx_frames_left", 32'(tx_len_q.size()), 32'd0);
    check("end_rx_a_left", 32'(rxq_a.size()), 32'd0);
    check("end_rx_b_left", 32'(rxq_b.size()), 32'd0);
    check("end_rx_c_left", 32'(rxq_c.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
